// File: rtl/memory_be.sv
// -----------------------------------------------------------------------------
// memory_be -- single-port word memory with per-byte write enables.
//
// After every reset the block sweeps the whole array to zero (INIT state, one
// word per clock, ready low). Once the sweep finishes it sits in IDLE and
// serves one request per cycle:
//   * write : only the bytes whose byte_en bit is set are updated
//   * read  : registered result, read_data/read_valid one cycle later
//   * write+read together : the write wins, the read is dropped and
//                           cmd_conflict pulses one cycle later
//   * address >= DEPTH    : nothing happens except an addr_err pulse
//
// Optional feature: define MEM_PARITY_EN to store one even-parity bit per byte
// and flag a recomputed mismatch on read (parity_err, coincident with
// read_valid). Without the macro no parity is stored and parity_err is 0.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset, restarts the INIT sweep
//   mem_write    in   write request (sampled while ready=1)
//   mem_read     in   read request (sampled while ready=1)
//   address      in   word address [ADDR_WIDTH]
//   write_data   in   write word [DATA_WIDTH]
//   byte_en      in   byte write enables, bit i covers bits 8i+7:8i
//   ready        out  block accepts requests
//   read_data    out  registered read word, holds while read_valid=0
//   read_valid   out  one-cycle pulse qualifying read_data
//   addr_err     out  one-cycle pulse, accepted request had address >= DEPTH
//   cmd_conflict out  one-cycle pulse, write and read requested together
//   parity_err   out  one-cycle pulse with read_valid on parity mismatch
// -----------------------------------------------------------------------------
module memory_be #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_write,
    input  logic                    mem_read,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    addr_err,
    output logic                    cmd_conflict,
    output logic                    parity_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;

    logic                   ready_q, ready_d;
    logic [DATA_WIDTH-1:0]  read_data_q, read_data_d;
    logic                   read_valid_q, read_valid_d;
    logic                   addr_err_q, addr_err_d;
    logic                   cmd_conflict_q, cmd_conflict_d;
    logic                   parity_err_q, parity_err_d;

    logic                   idle_s;
    logic                   in_range_s;
    logic [IDX_W-1:0]       idx_s;
    logic                   wr_acc_s;
    logic                   rd_acc_s;

    logic                   mem_we_s;
    logic [IDX_W-1:0]       mem_idx_s;
    logic [DATA_WIDTH-1:0]  mem_wdata_s;
    logic [NB-1:0]          mem_be_s;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

`ifdef MEM_PARITY_EN
    // Even parity per byte: the stored bit makes the byte plus parity even.
    function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] word);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) begin
            p[b] = ^word[8*b +: 8];
        end
        return p;
    endfunction

    logic [NB-1:0]          par_q [DEPTH];
    logic [NB-1:0]          new_par_s;

    assign new_par_s = byte_parity(mem_wdata_s);
`endif

    // FSM next state: INIT walks the clear counter, IDLE is terminal until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_INIT;
                    cnt_d   = cnt_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Request decode: only IDLE accepts, out-of-range requests never touch the array.
    always_comb begin
        idle_s     = (state_q == ST_IDLE);
        in_range_s = ({1'b0, address} < DEPTH_W);
        idx_s      = address[IDX_W-1:0];
        wr_acc_s   = idle_s & mem_write & in_range_s;
        rd_acc_s   = idle_s & mem_read & ~mem_write & in_range_s;
    end

    // Array write port mux: the INIT sweep owns the port, otherwise the request does.
    always_comb begin
        if (state_q == ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_idx_s   = cnt_q;
            mem_wdata_s = '0;
            mem_be_s    = '1;
        end else begin
            mem_we_s    = wr_acc_s;
            mem_idx_s   = idx_s;
            mem_wdata_s = write_data;
            mem_be_s    = byte_en;
        end
    end

    // Output next values; read_data keeps its old value when no read completes.
    always_comb begin
        ready_d        = (state_d == ST_IDLE);
        read_valid_d   = rd_acc_s;
        addr_err_d     = idle_s & (mem_write | mem_read) & ~in_range_s;
        cmd_conflict_d = idle_s & mem_write & mem_read;
        if (rd_acc_s) begin
            read_data_d = mem_q[idx_s];
        end else begin
            read_data_d = read_data_q;
        end
        parity_err_d   = 1'b0;
`ifdef MEM_PARITY_EN
        if (rd_acc_s) begin
            parity_err_d = |(par_q[idx_s] ^ byte_parity(mem_q[idx_s]));
        end else begin
            parity_err_d = 1'b0;
        end
`endif
    end

    // Array storage: byte-granular write, no reset (INIT clears it).
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be_s[b]) begin
                    mem_q[mem_idx_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
                end
            end
        end
    end

`ifdef MEM_PARITY_EN
    // Parity storage follows the same byte enables as the data array.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be_s[b]) begin
                    par_q[mem_idx_s][b] <= new_par_s[b];
                end
            end
        end
    end
`endif

    // Control and output registers; reset discards any in-flight read result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            cnt_q          <= '0;
            ready_q        <= 1'b0;
            read_data_q    <= '0;
            read_valid_q   <= 1'b0;
            addr_err_q     <= 1'b0;
            cmd_conflict_q <= 1'b0;
            parity_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ready_q        <= ready_d;
            read_data_q    <= read_data_d;
            read_valid_q   <= read_valid_d;
            addr_err_q     <= addr_err_d;
            cmd_conflict_q <= cmd_conflict_d;
            parity_err_q   <= parity_err_d;
        end
    end

    assign ready        = ready_q;
    assign read_data    = read_data_q;
    assign read_valid   = read_valid_q;
    assign addr_err     = addr_err_q;
    assign cmd_conflict = cmd_conflict_q;
    assign parity_err   = parity_err_q;

endmodule

// File: tb/tb_memory_be.sv
// -----------------------------------------------------------------------------
// tb_memory_be -- bench for memory_be. Two instances share clock and reset:
// dut_a uses the default DEPTH=256, dut_b uses DEPTH=200 for the address
// boundary. Reference memories model every write; each driven read pushes
// the expected word to a queue that is popped when read_valid appears.
// -----------------------------------------------------------------------------
module tb_memory_be;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_write, a_read;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic        a_ready, a_rvalid, a_aerr, a_conf, a_perr;
    logic [31:0] a_rdata;

    logic        b_write, b_read;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic        b_ready, b_rvalid, b_aerr, b_conf, b_perr;
    logic [31:0] b_rdata;

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [31:0] model_a [256];
    logic [31:0] model_b [200];
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    memory_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .mem_write(a_write), .mem_read(a_read),
        .address(a_addr), .write_data(a_wdata), .byte_en(a_be),
        .ready(a_ready), .read_data(a_rdata), .read_valid(a_rvalid),
        .addr_err(a_aerr), .cmd_conflict(a_conf), .parity_err(a_perr)
    );

    memory_be #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200)) dut_b (
        .clk(clk), .rst_n(rst_n), .mem_write(b_write), .mem_read(b_read),
        .address(b_addr), .write_data(b_wdata), .byte_en(b_be),
        .ready(b_ready), .read_data(b_rdata), .read_valid(b_rvalid),
        .addr_err(b_aerr), .cmd_conflict(b_conf), .parity_err(b_perr)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1);
    end

    task automatic clear_models();
        for (int i = 0; i < 256; i++) model_a[i] = 32'd0;
        for (int i = 0; i < 200; i++) model_b[i] = 32'd0;
        exp_q.delete();
    endtask

    // Drive one request on dut_a at the falling edge and update the model.
    task automatic drive_a(input logic w, input logic r, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        a_write = w; a_read = r; a_addr = a; a_wdata = d; a_be = be;
        if (r && !w) exp_q.push_back(model_a[a]);
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_a[a][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic drive_b(input logic w, input logic r, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        b_write = w; b_read = r; b_addr = a; b_wdata = d; b_be = be;
        if (a < 8'd200) begin
            if (r && !w) exp_q.push_back(model_b[a]);
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model_b[a][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
    endtask

    // Count rising edges until each instance raises ready; note any read_valid.
    task automatic measure_init(output int ca, output int cb, output bit rv_seen);
        ca = 0; cb = 0; rv_seen = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (a_rvalid || b_rvalid) rv_seen = 1'b1;
            if (ca == 0 && a_ready) ca = i;
            if (cb == 0 && b_ready) cb = i;
            if (ca != 0 && cb != 0) break;
        end
    endtask

    task automatic test_reset();
        int ca, cb;
        bit rv_seen;
        rst_n = 1'b0;
        a_write = 1'b0; a_read = 1'b0; a_addr = 8'd0; a_wdata = 32'd0; a_be = 4'd0;
        b_write = 1'b0; b_read = 1'b0; b_addr = 8'd0; b_wdata = 32'd0; b_be = 4'd0;
        clear_models();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_ready, a_rvalid, a_rdata, a_aerr, a_conf, a_perr} !== 37'd0)
            $display("FAIL reset_outputs_a: got %h want 0", {a_ready, a_rvalid, a_rdata, a_aerr, a_conf, a_perr});
        else n_pass++;
        n_checks++;
        if ({b_ready, b_rvalid, b_rdata, b_aerr, b_conf, b_perr} !== 37'd0)
            $display("FAIL reset_outputs_b: got %h want 0", {b_ready, b_rvalid, b_rdata, b_aerr, b_conf, b_perr});
        else n_pass++;
        // Requests held during INIT must be ignored.
        a_read = 1'b1; a_addr = 8'h10;
        @(negedge clk);
        rst_n = 1'b1;
        measure_init(ca, cb, rv_seen);
        a_read = 1'b0;
        n_checks++;
        if (ca !== 256) $display("FAIL init_len_a: got %0d cycles want 256", ca);
        else n_pass++;
        n_checks++;
        if (cb !== 200) $display("FAIL init_len_b: got %0d cycles want 200", cb);
        else n_pass++;
        n_checks++;
        if (rv_seen !== 1'b0) $display("FAIL init_no_read_valid: got %b want 0", rv_seen);
        else n_pass++;
    endtask

    task automatic test_init_read();
        drive_a(1'b0, 1'b1, 8'h10, 32'd0, 4'd0);
        drive_a(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
        n_checks++;
        if (a_rvalid !== 1'b1) $display("FAIL init_read_valid: got %b want 1", a_rvalid);
        else n_pass++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (a_rdata !== exp_v) $display("FAIL init_read_data: got %h want %h", a_rdata, exp_v);
        else n_pass++;
        n_checks++;
        if (a_perr !== 1'b0) $display("FAIL init_read_parity: got %b want 0", a_perr);
        else n_pass++;
        drive_a(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
        n_checks++;
        if (a_rvalid !== 1'b0) $display("FAIL read_valid_pulse: got %b want 0", a_rvalid);
        else n_pass++;
    endtask

    task automatic test_byte_en();
        drive_a(1'b1, 1'b0, 8'h01, 32'hA5A5_A5A5, 4'hF);
        drive_a(1'b1, 1'b0, 8'h01, 32'h5A5A_5A5A, 4'b0101);
        n_checks++;
        if (a_rvalid !== 1'b0) $display("FAIL write_no_read_valid: got %b want 0", a_rvalid);
        else n_pass++;
        // Read on the cycle right after the write must see the merged word.
        drive_a(1'b0, 1'b1, 8'h01, 32'd0, 4'd0);
        drive_a(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== exp_v)
            $display("FAIL byte_en_merge: got valid=%b data=%h want valid=1 data=%h", a_rvalid, a_rdata, exp_v);
        else n_pass++;
        drive_a(1'b1, 1'b0, 8'h01, 32'hFFFF_FFFF, 4'h0);
        drive_a(1'b0, 1'b1, 8'h01, 32'd0, 4'd0);
        drive_a(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== exp_v)
            $display("FAIL byte_en_zero: got valid=%b data=%h want valid=1 data=%h", a_rvalid, a_rdata, exp_v);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] last_v;
        last_v = 32'd0;
        drive_a(1'b1, 1'b0, 8'h02, 32'h0BAD_F00D, 4'hF);
        drive_a(1'b1, 1'b0, 8'h03, 32'hC0DE_1234, 4'hF);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive_a(1'b0, 1'b1, 8'(i + 1), 32'd0, 4'd0);
            else       drive_a(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
            if (i > 0) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                last_v = exp_v;
                n_checks++;
                if (a_rvalid !== 1'b1 || a_rdata !== exp_v)
                    $display("FAIL b2b_read_%0d: got valid=%b data=%h want valid=1 data=%h", i, a_rvalid, a_rdata, exp_v);
                else n_pass++;
            end
        end
        drive_a(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
        n_checks++;
        if (a_rvalid !== 1'b0 || a_rdata !== last_v)
            $display("FAIL read_data_hold: got valid=%b data=%h want valid=0 data=%h", a_rvalid, a_rdata, last_v);
        else n_pass++;
    endtask

    task automatic test_conflict();
        drive_a(1'b1, 1'b1, 8'h04, 32'h1234_5678, 4'hF);
        drive_a(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
        n_checks++;
        if (a_conf !== 1'b1 || a_rvalid !== 1'b0)
            $display("FAIL conflict_pulse: got conflict=%b valid=%b want conflict=1 valid=0", a_conf, a_rvalid);
        else n_pass++;
        drive_a(1'b0, 1'b1, 8'h04, 32'd0, 4'd0);
        n_checks++;
        if (a_conf !== 1'b0) $display("FAIL conflict_one_cycle: got %b want 0", a_conf);
        else n_pass++;
        drive_a(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== exp_v)
            $display("FAIL conflict_write_kept: got valid=%b data=%h want valid=1 data=%h", a_rvalid, a_rdata, exp_v);
        else n_pass++;
    endtask

    task automatic test_addr_err();
        drive_b(1'b0, 1'b1, 8'hC8, 32'd0, 4'd0);
        drive_b(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
        n_checks++;
        if (b_aerr !== 1'b1 || b_rvalid !== 1'b0)
            $display("FAIL addr_err_read: got err=%b valid=%b want err=1 valid=0", b_aerr, b_rvalid);
        else n_pass++;
        drive_b(1'b1, 1'b0, 8'hC8, 32'hFFFF_FFFF, 4'hF);
        n_checks++;
        if (b_aerr !== 1'b0) $display("FAIL addr_err_one_cycle: got %b want 0", b_aerr);
        else n_pass++;
        drive_b(1'b1, 1'b0, 8'hC7, 32'h7E57_C0DE, 4'hF);
        n_checks++;
        if (b_aerr !== 1'b1) $display("FAIL addr_err_write: got %b want 1", b_aerr);
        else n_pass++;
        drive_b(1'b0, 1'b1, 8'hC7, 32'd0, 4'd0);
        n_checks++;
        if (b_aerr !== 1'b0) $display("FAIL addr_last_valid_write: got err=%b want 0", b_aerr);
        else n_pass++;
        drive_b(1'b0, 1'b1, 8'h48, 32'd0, 4'd0);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== exp_v)
            $display("FAIL addr_last_valid_read: got valid=%b data=%h want valid=1 data=%h", b_rvalid, b_rdata, exp_v);
        else n_pass++;
        drive_b(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== exp_v)
            $display("FAIL addr_no_alias: got valid=%b data=%h want valid=1 data=%h", b_rvalid, b_rdata, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int ca, cb;
        bit rv_seen;
        drive_a(1'b0, 1'b1, 8'h01, 32'd0, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_models();
        #1;
        n_checks++;
        if (a_rvalid !== 1'b0 || a_ready !== 1'b0)
            $display("FAIL reset_drops_read: got valid=%b ready=%b want valid=0 ready=0", a_rvalid, a_ready);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        measure_init(ca, cb, rv_seen);
        n_checks++;
        if (ca !== 256 || cb !== 200)
            $display("FAIL reinit_len: got a=%0d b=%0d want a=256 b=200", ca, cb);
        else n_pass++;
        n_checks++;
        if (rv_seen !== 1'b0) $display("FAIL reinit_no_read_valid: got %b want 0", rv_seen);
        else n_pass++;
        // Word 1 held A55AA55A before reset; the sweep must have cleared it.
        drive_a(1'b0, 1'b1, 8'h01, 32'd0, 4'd0);
        drive_a(1'b0, 1'b0, 8'h00, 32'd0, 4'd0);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== exp_v)
            $display("FAIL reinit_cleared: got valid=%b data=%h want valid=1 data=%h", a_rvalid, a_rdata, exp_v);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_byte_en();
        test_back_to_back();
        test_conflict();
        test_addr_err();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
